mc_controller: RTL
==================

# mc_controller

Multicycle ARM control unit. It replaces the single-cycle control path with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles, and it waits on a memory ready handshake. The unit holds the NZCV flag register with condition gating. It raises a sticky fault on undefined opcodes or a memory timeout. It sits between the instruction register and the shared-memory multicycle datapath.

## Interface
Parameters:
- MEM_TIMEOUT, default 16: maximum wait cycles in any memory state before a fault; 0 disables the timeout.
- CNT_W, default 8: width of the wait counter; MEM_TIMEOUT must be below 2^CNT_W.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- Instr  in  20  IR bits [31:12]; stable from DECODE until the next FETCH.
- ALUFlags  in  4  NZCV from the ALU in the current cycle.
- MemReady  in  1  memory completes the access this cycle.
- PCWrite, IRWrite, RegWrite, MemWrite  out  1  write enables.
- AdrSrc, ALUSrcA  out  1  datapath muxes (0 = PC address, 1 = ALU result; A: 0 = Rn, 1 = PC).
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2  datapath muxes.
- ALUControl  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 0100 EOR, 0101 pass B.
- storedCarry  out  1  C bit of the flag register.
- Fault  out  1  sticky fault indicator.
- StateDbg  out  4  current state encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, FAULT.
- FETCH:
  - Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
  - Holds while MemReady=0.
  - When MemReady=1: IRWrite=1, PCWrite=1, next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (PC+8). Next state by Op=Instr[27:26]:
  - 00 → EXECI if I=1, else EXECR.
  - 01 → MEMADR.
  - 10 → BRANCH.
  - 11 → FAULT.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD (SUB when U=0). Next MEMRD if L=1, else MEMWR.
- MEMRD: AdrSrc=1; holds until MemReady, then MEMWB.
- MEMWR: AdrSrc=1; MemWrite=CondEx; holds until MemReady, then FETCH.
- MEMWB: ResultSrc=01, RegWrite=CondEx. If Rd=15, also PCWrite=CondEx. Next FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI); next ALUWB.
- ALUWB:
  - ResultSrc=00; RegWrite=CondEx, except CMP/TST and cmd codes with no write.
  - Rd=15 also sets PCWrite=CondEx.
  - Next FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx; next FETCH.
- Cmd decode (Instr[24:21]):
  - 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 0001→EOR, 1101→pass B, 1010 CMP→SUB with no write.
  - Any other cmd → FAULT from DECODE.
- FlagW: in EXECR/EXECI, if S=1 and CondEx, NZ are written. CV are written only for ADD/SUB/CMP.
- CondEx: evaluated from Instr[31:28] against the registered flags, using all 15 ARM conditions; 1111 is treated as never.
- Fault behaviour:
  - FAULT is absorbing; only reset leaves it.
  - All write enables are 0 in FAULT; Fault=1.

## Timing
- Latency with MemReady always 1: B 3 cycles, data-processing 4, STR 4, LDR 5.
- Every wait cycle adds 1 cycle.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD or MEMWR.
  - Increments each cycle spent in that state with MemReady=0.
  - When the counter equals MEM_TIMEOUT and MemReady=0, the next state is FAULT.
  - If MemReady=1 in that same cycle, the access completes and no fault is raised.
- Flag register updates on the clock edge that ends the EXEC state; ALUWB already sees the new flags.
- Reset takes priority over everything, including a mid-access wait. After reset:
  - State is FETCH, flags 0000, counter 0.
  - Fault=0, storedCarry=0.
  - All write enables are 0 until MemReady.
- Outputs are Moore with respect to state plus IR fields. The only exceptions are the MemReady-gated IRWrite/PCWrite in FETCH and the timeout check.

## Structure
- arm_ctrl_pkg: state enum, ALUControl codes, cond codes, cmd codes, Op field values.
- Sub-module mc_cond_unit: flag register, CondEx evaluation, FlagW gating, storedCarry.
- The FSM and output decode stay in mc_controller.

## Test plan
- ADD R1,R2,R3 (E0821003), MemReady=1 → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; ALUControl=0000.
- CMP setting Z=1, then ADDNE → the ADDNE reaches ALUWB with RegWrite=0; storedCarry matches the C produced by the CMP.
- LDR with MemReady low for 3 cycles in MEMRD → LDR takes 8 cycles; RegWrite=1 in MEMWB only.
- MEM_TIMEOUT=4 with MemReady stuck low in FETCH → FAULT after the 5th FETCH cycle; Fault=1 persists; reset → FETCH, Fault=0.
- Op=11 instruction → DECODE goes to FAULT; no write enable is ever asserted.
- Reset asserted during MEMWR wait → MemWrite=0 next cycle; state FETCH; flags 0000.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// mc_controller_pkg: shared state, ALU, condition, command and opcode encodings for the multicycle control unit
package mc_controller_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
  } state_t;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;
  localparam logic [3:0] ALU_EOR = 4'b0100;
  localparam logic [3:0] ALU_PASSB = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [1:0] OP_DP = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;
  function automatic logic cmd_valid(input logic [3:0] c);
    return c inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_EOR, CMD_MOV, CMD_CMP};
  endfunction
  function automatic logic [3:0] cmd_alu(input logic [3:0] c);
    return c == CMD_ADD ? ALU_ADD :
           (c == CMD_SUB || c == CMD_CMP) ? ALU_SUB :
           c == CMD_AND ? ALU_AND :
           c == CMD_ORR ? ALU_ORR :
           c == CMD_EOR ? ALU_EOR : ALU_PASSB;
  endfunction
endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: instruction, flag and memory-ready inputs plus all datapath control outputs
interface mc_controller_if;
  logic [19:0] Instr;
  logic [3:0] ALUFlags;
  logic MemReady;
  logic PCWrite, IRWrite, RegWrite, MemWrite;
  logic AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl;
  logic storedCarry, Fault;
  logic [3:0] StateDbg;
  modport master(
    input Instr, ALUFlags, MemReady,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
    output ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, storedCarry, Fault, StateDbg
  );
  modport slave(
    output Instr, ALUFlags, MemReady,
    input PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
    input ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, storedCarry, Fault, StateDbg
  );
endinterface

// File: rtl/mc_controller_cond_unit.sv
// mc_cond_unit: NZCV flag register, condition evaluation and S-bit gated flag writes
module mc_cond_unit
  import mc_controller_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic flag_upd,
  input  logic s_bit,
  input  logic cv_upd,
  output logic cond_ex,
  output logic stored_carry
);
  logic [3:0] flags;
  logic n, z, c, v, nz_we, cv_we;
  assign {n, z, c, v} = flags;
  assign nz_we = flag_upd & s_bit & cond_ex;
  assign cv_we = nz_we & cv_upd;
  assign stored_carry = c;
  // condition check against the registered flags; 1111 never executes
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = !z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = !c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = !n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = !v;
      COND_HI: cond_ex = c & !z;
      COND_LS: cond_ex = !c | z;
      COND_GE: cond_ex = n == v;
      COND_LT: cond_ex = n != v;
      COND_GT: cond_ex = !z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
  // NZ follow any flag-setting op; CV only arithmetic ones
  always_ff @(posedge clk) begin
    if (reset) flags <= '0;
    else begin
      if (nz_we) flags[3:2] <= alu_flags[3:2];
      if (cv_we) flags[1:0] <= alu_flags[1:0];
    end
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM control FSM with memory wait timeout and sticky fault
module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  mc_controller_if.master bus
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);
  state_t state, next;
  logic [CNT_W-1:0] cnt;
  logic [3:0] cond, cmd, rd;
  logic [1:0] op;
  logic i_bit, s_bit, u_bit, l_bit, rd15, cond_ex, in_exec, arith, wr_ok, waiting, tmo;
  logic unused_rn;
  assign cond = bus.Instr[19:16];
  assign op = bus.Instr[15:14];
  assign i_bit = bus.Instr[13];
  assign cmd = bus.Instr[12:9];
  assign u_bit = bus.Instr[11];
  assign s_bit = bus.Instr[8];
  assign l_bit = bus.Instr[8];
  assign rd = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];
  assign rd15 = rd == 4'hF;
  assign in_exec = state == S_EXECR || state == S_EXECI;
  assign arith = cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP;
  assign wr_ok = cmd != CMD_CMP;
  assign waiting = state == S_FETCH || state == S_MEMRD || state == S_MEMWR;
  assign tmo = MEM_TIMEOUT != 0 && cnt == TMO && !bus.MemReady;
  assign bus.ImmSrc = op;
  assign bus.RegSrc = {op == OP_MEM, op == OP_BR};
  assign bus.Fault = state == S_FAULT;
  assign bus.StateDbg = state;
  mc_cond_unit u_cond (
    .clk(clk),
    .reset(reset),
    .cond(cond),
    .alu_flags(bus.ALUFlags),
    .flag_upd(in_exec),
    .s_bit(s_bit),
    .cv_upd(arith),
    .cond_ex(cond_ex),
    .stored_carry(bus.storedCarry)
  );
  // state register and wait counter, which restarts on every state entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      cnt <= '0;
    end else begin
      state <= next;
      cnt <= next != state ? '0 : (waiting && !bus.MemReady) ? cnt + CNT_W'(1) : cnt;
    end
  end
  // next state and Moore control decode
  always_comb begin
    next = state;
    bus.PCWrite = 1'b0;
    bus.IRWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.MemWrite = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        next = bus.MemReady ? S_DECODE : tmo ? S_FAULT : S_FETCH;
      end
      S_DECODE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        next = op == OP_MEM ? S_MEMADR :
               op == OP_BR ? S_BRANCH :
               (op == OP_DP && cmd_valid(cmd)) ? (i_bit ? S_EXECI : S_EXECR) : S_FAULT;
      end
      S_MEMADR: begin
        bus.ALUSrcB = 2'b01;
        bus.ALUControl = u_bit ? ALU_ADD : ALU_SUB;
        next = l_bit ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.AdrSrc = 1'b1;
        next = bus.MemReady ? S_MEMWB : tmo ? S_FAULT : S_MEMRD;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        bus.MemWrite = cond_ex;
        next = bus.MemReady ? S_FETCH : tmo ? S_FAULT : S_MEMWR;
      end
      S_MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite = cond_ex;
        bus.PCWrite = cond_ex & rd15;
        next = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        bus.ALUSrcB = state == S_EXECI ? 2'b01 : 2'b00;
        bus.ALUControl = cmd_alu(cmd);
        next = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = cond_ex & wr_ok;
        bus.PCWrite = cond_ex & wr_ok & rd15;
        next = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcB = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite = cond_ex;
        next = S_FETCH;
      end
      default: next = S_FAULT;
    endcase
  end
endmodule
